// File: rtl/scanline_buffer_if.sv
// -----------------------------------------------------------------------------
// scanline_buffer_if
// Renderer-side port of the scanline buffer: line request and pixel write
// handshake.
//   line_req  : one-cycle pulse, renderer must start producing line line_num
//   line_num  : line being requested, held until the next request
//   wr_valid  : renderer pixel valid
//   wr_ready  : buffer accepts a pixel this cycle
//   wr_data   : pixel colour (RRGGBB)
// Modports: master = renderer, slave = scanline buffer.
// -----------------------------------------------------------------------------
interface scanline_buffer_if #(
   parameter int COLOR_W = 6
);
   logic               line_req;
   logic [9:0]         line_num;
   logic               wr_valid;
   logic               wr_ready;
   logic [COLOR_W-1:0] wr_data;

   modport master (
      input  line_req, line_num, wr_ready,
      output wr_valid, wr_data
   );

   modport slave (
      output line_req, line_num, wr_ready,
      input  wr_valid, wr_data
   );
endinterface

// File: rtl/scanline_buffer.sv
// -----------------------------------------------------------------------------
// scanline_buffer
// Double-buffered 160-entry line store sitting behind a 640x480@60 timing
// generator. One bank is shown at 4x horizontal replication while the renderer
// fills the other bank with the next scanline. Banks swap at x==640 of every
// row; lines are requested one line ahead of display.
//
// Ports:
//   clk, reset       : pixel clock, asynchronous active-high reset
//   x, y             : timing-generator column / row
//   blank            : high outside the 640x480 active area
//   hs_in, vs_in     : active-low syncs from the timing generator
//   rnd (slave)      : line request + valid/ready pixel write port
//   rgb              : registered pixel output (latency 2)
//   hs_out, vs_out   : syncs delayed 2 cycles to match rgb
//   underrun         : sticky, a requested line was incomplete at swap time
//
// Optional build macro: SCANBUF_UNDERRUN_COLOR_EN
//   Defined     : the line following an underrun is shown in magenta.
//   Not defined : the stale display bank is simply repeated.
// -----------------------------------------------------------------------------
module scanline_buffer #(
   parameter int LINE_PIX = 160,
   parameter int COLOR_W  = 6,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic               blank,
   input  logic               hs_in,
   input  logic               vs_in,
   scanline_buffer_if.slave   rnd,
   output logic [COLOR_W-1:0] rgb,
   output logic               hs_out,
   output logic               vs_out,
   output logic               underrun
);
   localparam int IDX_W  = $clog2(LINE_PIX + 1);
   localparam int ADDR_W = $clog2(2 * LINE_PIX);
   localparam logic [9:0]        EVT_X     = 10'(4 * LINE_PIX);
   localparam logic [10:0]       V_TOTAL_W = 11'(V_TOTAL);
   localparam logic [9:0]        V_ACT_W   = 10'(V_ACTIVE);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_PIX - 1);
   localparam logic [ADDR_W-1:0] BANK_OFS  = ADDR_W'(LINE_PIX);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic               disp_sel_reg;
   logic               disp_valid_reg;
   logic               underrun_reg;
   logic               line_req_reg;
   logic [9:0]         line_num_reg;

   logic               accept, last_accept, line_evt, req_line;
   logic               swap, abort;
   logic [10:0]        y_plus2;
   logic [9:0]         target;

   // ---------------- control decode ----------------
   assign accept      = rnd.wr_valid && (state_reg == FILL);
   assign last_accept = accept && (idx_reg == LAST_IDX);
   assign line_evt    = (x == EVT_X);
   // A final accept landing on the event edge still counts as a full line.
   assign swap        = line_evt && ((state_reg == DONE) || last_accept);
   assign abort       = line_evt && (state_reg == FILL) && !last_accept;

   assign y_plus2  = {1'b0, y} + 11'd2;
   assign target   = (y_plus2 >= V_TOTAL_W) ? 10'(y_plus2 - V_TOTAL_W) : y_plus2[9:0];
   assign req_line = (target < V_ACT_W);

   // ---------------- fill FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (state_reg == FILL && last_accept)
         state_next = DONE;
      if (line_evt) begin
         // Every line event ends the current fill (swap, abort or no-op);
         // a new request restarts it on the same edge.
         state_next = IDLE;
         if (req_line)
            state_next = FILL;
      end
   end

   always_comb begin
      rnd.wr_ready = (state_reg == FILL);
   end

   // ---------------- fill / swap datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg        <= '0;
         disp_sel_reg   <= 1'b0;
         disp_valid_reg <= 1'b0;
         underrun_reg   <= 1'b0;
         line_req_reg   <= 1'b0;
         line_num_reg   <= '0;
      end else begin
         line_req_reg <= line_evt && req_line;
         if (line_evt)
            idx_reg <= '0;
         else if (accept)
            idx_reg <= last_accept ? '0 : idx_reg + 1'b1;
         if (swap) begin
            disp_sel_reg   <= ~disp_sel_reg;
            disp_valid_reg <= 1'b1;
         end
         if (abort)
            underrun_reg <= 1'b1;
         if (line_evt && req_line)
            line_num_reg <= target;
      end
   end

   assign rnd.line_req = line_req_reg;
   assign rnd.line_num = line_num_reg;
   assign underrun     = underrun_reg;

   // ---------------- line store (both banks in one array) ----------------
   logic [COLOR_W-1:0] mem [0:2*LINE_PIX-1];
   logic [ADDR_W-1:0]  wr_addr, rd_addr;
   logic [7:0]         col, col_safe;
   logic [COLOR_W-1:0] rd_data;

   // Fill bank is always the one not on display, so read and write never collide.
   assign wr_addr  = ADDR_W'(idx_reg) + (disp_sel_reg ? '0 : BANK_OFS);
   assign col      = x[9:2];
   // Columns 160..199 only occur in blanking; gate them to entry 0.
   assign col_safe = (col < 8'(LINE_PIX)) ? col : 8'd0;
   assign rd_addr  = ADDR_W'(col_safe) + (disp_sel_reg ? BANK_OFS : '0);

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_addr] <= rnd.wr_data;
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

   // ---------------- display pipeline ----------------
   logic               blank_d, hs_d, vs_d;
   logic [COLOR_W-1:0] pix;

`ifdef SCANBUF_UNDERRUN_COLOR_EN
   localparam logic [COLOR_W-1:0] UNDERRUN_COLOR = COLOR_W'(6'b110011);
   logic bad_line_reg;

   // Marks the line displayed after an aborted fill; lives until the next event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         bad_line_reg <= 1'b0;
      else if (line_evt) bad_line_reg <= abort;
   end

   assign pix = bad_line_reg ? UNDERRUN_COLOR : (disp_valid_reg ? rd_data : '0);
`else
   assign pix = disp_valid_reg ? rd_data : '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_d <= 1'b1;
         hs_d    <= 1'b1;
         vs_d    <= 1'b1;
         rgb     <= '0;
         hs_out  <= 1'b1;
         vs_out  <= 1'b1;
      end else begin
         blank_d <= blank;
         hs_d    <= hs_in;
         vs_d    <= vs_in;
         rgb     <= blank_d ? '0 : pix;
         hs_out  <= hs_d;
         vs_out  <= vs_d;
      end
   end
endmodule

// File: tb/tb_scanline_buffer.sv
// -----------------------------------------------------------------------------
// tb_scanline_buffer
// Directed bench for scanline_buffer. The timing generator is emulated by
// driving x/y directly (jumping between rows) and the renderer by filling
// lines with pixel value (idx + line) & 63.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scanline_buffer;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x, y;
   logic       blank, hs_in, vs_in;
   logic [5:0] rgb;
   logic       hs_out, vs_out, underrun;

   int errors = 0;
   int checks = 0;

`ifdef SCANBUF_UNDERRUN_COLOR_EN
   localparam int MAGENTA_EN = 1;
`else
   localparam int MAGENTA_EN = 0;
`endif

   scanline_buffer_if rnd_if ();

   scanline_buffer dut (
      .clk      (clk),
      .reset    (reset),
      .x        (x),
      .y        (y),
      .blank    (blank),
      .hs_in    (hs_in),
      .vs_in    (vs_in),
      .rnd      (rnd_if),
      .rgb      (rgb),
      .hs_out   (hs_out),
      .vs_out   (vs_out),
      .underrun (underrun)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_xy(input int xv, input int yv);
      x     = 10'(xv);
      y     = 10'(yv);
      blank = (xv >= 640) || (yv >= 480);
      hs_in = !(xv >= 656 && xv <= 751);
      vs_in = !(yv >= 490 && yv <= 491);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present (xv,yv) for one cycle; on return outputs reflect that edge.
   task automatic drive(input int xv, input int yv);
      set_xy(xv, yv);
      tick();
   endtask

   task automatic line_event(input int yv, input logic exp_req, input int exp_num);
      drive(640, yv);
      check($sformatf("line_req_row%0d", yv), rnd_if.line_req, exp_req);
      check($sformatf("line_num_row%0d", yv), rnd_if.line_num, exp_num);
      $display("event row %0d: line_req=%0b line_num=%0d underrun=%0b",
               yv, rnd_if.line_req, rnd_if.line_num, underrun);
   endtask

   task automatic fill_line(input int ln, input int n);
      check($sformatf("ready_fill%0d", ln), rnd_if.wr_ready, 1);
      for (int i = 0; i < n; i++) begin
         rnd_if.wr_valid = 1'b1;
         rnd_if.wr_data  = 6'((i + ln) & 63);
         drive(700, int'(y));
      end
      rnd_if.wr_valid = 1'b0;
      $display("fill line %0d: %0d pixels written", ln, n);
   endtask

   // Hold a column long enough for the 2-stage pipeline, then compare.
   task automatic pixel(input int xv, input int yv, input int exp, input string tag);
      drive(xv, yv);
      drive(xv, yv);
      check(tag, rgb, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_y;
      reset = 1'b1;
      rnd_if.wr_valid = 1'b0;
      rnd_if.wr_data  = '0;
      // Syncs low during reset: outputs must still read the reset value.
      set_xy(700, 490);
      tick();
      tick();
      check("rst_rgb", rgb, 0);
      check("rst_hs", hs_out, 1);
      check("rst_vs", vs_out, 1);
      check("rst_ready", rnd_if.wr_ready, 0);
      check("rst_req", rnd_if.line_req, 0);
      check("rst_num", rnd_if.line_num, 0);
      check("rst_underrun", underrun, 0);
      reset = 1'b0;

      // IDLE: wr_valid ignored, no request away from x==640.
      rnd_if.wr_valid = 1'b1;
      rnd_if.wr_data  = 6'h3F;
      for (int k = 300; k < 306; k++) begin
         drive(k, 200);
         check("idle_req", rnd_if.line_req, 0);
         check("idle_ready", rnd_if.wr_ready, 0);
      end
      rnd_if.wr_valid = 1'b0;

      // Row 523 requests line 0.
      line_event(523, 1, 0);
      fill_line(0, 160);
      check("ready_drop", rnd_if.wr_ready, 0);
      // DONE: valid held high must not write.
      rnd_if.wr_valid = 1'b1;
      rnd_if.wr_data  = 6'h3F;
      for (int k = 0; k < 4; k++) drive(700, 523);
      check("done_ready", rnd_if.wr_ready, 0);
      rnd_if.wr_valid = 1'b0;

      // Row 524 swaps line 0 in and requests line 1.
      line_event(524, 1, 1);
      check("underrun_ok0", underrun, 0);

      // Streamed line 0: sample after x=k shows the pixel of x=k-1 (2-cycle latency).
      for (int k = 0; k < 10; k++) begin
         drive(k, 0);
         check($sformatf("l0_x%0d", k), rgb, (k >= 1) ? ((k - 1) >> 2) : 0);
      end
      for (int k = 630; k < 640; k++) begin
         drive(k, 0);
         if (k >= 631) check($sformatf("l0_x%0d", k), rgb, ((k - 1) >> 2) & 63);
      end
      drive(641, 0);
      check("l0_x639", rgb, 31);
      drive(642, 0);
      check("l0_blank641", rgb, 0);
      drive(643, 0);
      check("l0_blank642", rgb, 0);

      fill_line(1, 160);
      line_event(0, 1, 2);
      pixel(8, 1, 3, "l1_x8");

      // Final accept on the event edge still swaps.
      fill_line(2, 159);
      rnd_if.wr_valid = 1'b1;
      rnd_if.wr_data  = 6'd33;
      line_event(1, 1, 3);
      rnd_if.wr_valid = 1'b0;
      check("underrun_edge", underrun, 0);
      pixel(636, 2, 33, "l2_x636");
      pixel(0, 2, 2, "l2_x0");

      fill_line(3, 160);
      line_event(2, 1, 4);
      fill_line(4, 160);
      line_event(3, 1, 5);
      pixel(8, 4, 6, "l4_x8");

      // Stall on line 5: underrun, stale line 4 (or magenta), line 6 still requested.
      fill_line(5, 100);
      line_event(4, 1, 6);
      check("underrun_set", underrun, 1);
      check("ready_after_abort", rnd_if.wr_ready, 1);
      pixel(8, 5, (MAGENTA_EN != 0) ? 51 : 6, "l5_x8");
      pixel(0, 5, (MAGENTA_EN != 0) ? 51 : 4, "l5_x0");

      fill_line(6, 160);
      line_event(5, 1, 7);
      pixel(8, 6, 8, "l6_x8");
      check("underrun_sticky", underrun, 1);

      // Last active line: row 477 requests 479, row 478 swaps it in with no request.
      line_event(477, 1, 479);
      fill_line(479, 160);
      line_event(478, 0, 479);
      pixel(8, 479, 33, "l479_x8");

      // HSYNC: low for x=656..751 on input, seen 2 cycles later.
      for (int k = 650; k < 662; k++) begin
         drive(k, 100);
         if (k >= 652) check($sformatf("hs_x%0d", k), hs_out, !((k - 1) >= 656 && (k - 1) <= 751));
      end
      for (int k = 748; k < 756; k++) begin
         drive(k, 100);
         if (k >= 750) check($sformatf("hs_x%0d", k), hs_out, !((k - 1) >= 656 && (k - 1) <= 751));
      end
      // VSYNC: low for rows 490..491.
      prev_y = 487;
      drive(100, prev_y);
      for (int r = 488; r < 494; r++) begin
         drive(100, r);
         check($sformatf("vs_y%0d", r), vs_out, !(prev_y >= 490 && prev_y <= 491));
         prev_y = r;
      end

      // Reset mid-frame clears everything; rgb stays 0 until a swap.
      drive(300, 200);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_underrun", underrun, 0);
      check("mid_rst_rgb", rgb, 0);
      check("mid_rst_hs", hs_out, 1);
      check("mid_rst_vs", vs_out, 1);
      check("mid_rst_ready", rnd_if.wr_ready, 0);
      check("mid_rst_req", rnd_if.line_req, 0);
      check("mid_rst_num", rnd_if.line_num, 0);
      pixel(8, 10, 0, "post_rst_rgb");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
